i2c_master_tx: RTL



---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_quarter_tick.sv | 36 +++
 rtl/i2c_master_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } i2c_master_state_e;

    localparam logic [6:0] SLV_ADDR      = 7'h55;
    localparam int         BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timebase: one tick every CLK_DIV clocks while enabled,
// plus the 2-bit quarter index within the current bit slot.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       tick,
    output logic [1:0] qtr
);

    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign tick = en && (div_cnt == LAST);

    // Held at zero while idle so the first quarter after start is full length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            qtr     <= 2'd0;
        end else if (!en) begin
            div_cnt <= '0;
            qtr     <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            qtr     <= qtr + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, 7-bit address + W, 0..MAX_BYTES data bytes, STOP.
// SCL/SDA are decoded from state and quarter index; SDA is open-drain.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             slave_addr,
    input  logic [2:0]             byte_cnt,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic                   SCL,
    inout  wire                    SDA
);

    localparam int            CW       = ($clog2(MAX_BYTES + 1) > 3) ? $clog2(MAX_BYTES + 1) : 3;
    localparam logic [CW-1:0] MAXB     = CW'(MAX_BYTES);
    localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

    i2c_master_state_e state, state_n;

    logic                   tick, slot_end, ack_smp, accept;
    logic [1:0]             qtr;
    logic                   sda_low, sda_in, ack_bit;
    logic [7:0]             shreg;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [2:0]             bit_cnt;
    logic [CW-1:0]          cnt_q, byte_idx, byte_nxt, cnt_in, cnt_clamp;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .tick  (tick),
        .qtr   (qtr)
    );

    assign busy      = (state != IDLE);
    assign accept    = start && !busy && !done;
    assign slot_end  = tick && (qtr == 2'd3);
    assign ack_smp   = tick && (qtr == 2'd2);
    assign byte_nxt  = byte_idx + CW'(1);
    assign cnt_in    = CW'(byte_cnt);
    assign cnt_clamp = (cnt_in > MAXB) ? MAXB : cnt_in;

    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        SCL     = 1'b1;
        sda_low = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = START;
            end
            START: begin
                SCL     = (qtr != 2'd3);
                sda_low = qtr[1];
                if (slot_end) state_n = ADDR;
            end
            ADDR, DATA: begin
                SCL     = qtr[1];
                sda_low = !shreg[7];
                if (slot_end && bit_cnt == LAST_BIT)
                    state_n = (state == ADDR) ? ADDR_ACK : DATA_ACK;
            end
            ADDR_ACK: begin
                SCL = qtr[1];
                if (slot_end)
                    state_n = (!ack_bit && cnt_q != '0) ? DATA : STOP;
            end
            DATA_ACK: begin
                SCL = qtr[1];
                if (slot_end)
                    state_n = (!ack_bit && byte_nxt < cnt_q) ? DATA : STOP;
            end
            STOP: begin
                // SDA released in the last quarter, rising while SCL is high
                SCL     = qtr[1];
                sda_low = (qtr != 2'd3);
                if (slot_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            nack_err <= 1'b0;
            ack_bit  <= 1'b0;
            shreg    <= '0;
            data_q   <= '0;
            bit_cnt  <= '0;
            cnt_q    <= '0;
            byte_idx <= '0;
        end else begin
            done <= (state == STOP) && slot_end;
            if (accept) begin
                cnt_q    <= cnt_clamp;
                data_q   <= tx_data;
                shreg    <= {slave_addr, 1'b0};
                bit_cnt  <= '0;
                byte_idx <= '0;
                nack_err <= 1'b0;
            end
            if (ack_smp && (state == ADDR_ACK || state == DATA_ACK)) begin
                ack_bit <= sda_in;
                if (sda_in) nack_err <= 1'b1;
            end
            if (slot_end) begin
                case (state)
                    ADDR, DATA: begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // Next byte is preloaded; harmless if the FSM heads to STOP.
                        if (!ack_bit) begin
                            shreg  <= data_q[7:0];
                            data_q <= data_q >> BITS_PER_BYTE;
                            if (state == DATA_ACK) byte_idx <= byte_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
